// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative write-back cache.
// Provides the controller state enum, replacement policy codes and address helpers.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK,
        FLUSH_SCAN,
        FLUSH_OUT
    } state_t;

    localparam int REPL_FIFO = 0;
    localparam int REPL_LRU  = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Extracts a width-bit field starting at bit lsb of a byte address.
    function automatic logic [31:0] addr_field(input logic [31:0] a,
                                               input int lsb,
                                               input int width);
        return (a >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_repl.sv
// Replacement state for every set: FIFO pointers or LRU ages, victim choice.
// Ports: clk, rst; set/valid select the victim for the addressed set;
// upd/fill/upd_set/upd_way apply a hit (fill=0) or line fill (fill=1).
module cache_repl
    import cache_pkg::*;
#(
    parameter int SET_ADDR_LEN = 2,
    parameter int WAY_CNT      = 4,
    parameter int REPL_POLICY  = 1,
    localparam int SETS  = 1 << SET_ADDR_LEN,
    localparam int WAY_W = (WAY_CNT > 1) ? clog2(WAY_CNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SET_ADDR_LEN-1:0] set,
    input  logic [WAY_CNT-1:0]      valid,
    output logic [WAY_W-1:0]        victim,
    input  logic                    upd,
    input  logic                    fill,
    input  logic [SET_ADDR_LEN-1:0] upd_set,
    input  logic [WAY_W-1:0]        upd_way
);

    logic [WAY_W-1:0] age [SETS][WAY_CNT];
    logic [WAY_W-1:0] ptr [SETS];
    logic             found;

    // Lowest invalid way wins; otherwise the policy decides.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            if (REPL_POLICY == REPL_LRU) begin
                for (int w = 0; w < WAY_CNT; w++) begin
                    if (age[set][w] == '0) victim = WAY_W'(w);
                end
            end else begin
                victim = ptr[set];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                ptr[s] <= '0;
                for (int w = 0; w < WAY_CNT; w++) age[s][w] <= WAY_W'(w);
            end
        end else if (upd) begin
            if (REPL_POLICY == REPL_LRU) begin
                for (int w = 0; w < WAY_CNT; w++) begin
                    if (age[upd_set][w] > age[upd_set][upd_way])
                        age[upd_set][w] <= age[upd_set][w] - WAY_W'(1);
                end
                age[upd_set][upd_way] <= WAY_W'(WAY_CNT - 1);
            end else if (fill && upd_way == ptr[upd_set]) begin
                ptr[upd_set] <= (ptr[upd_set] == WAY_W'(WAY_CNT - 1))
                              ? '0 : ptr[upd_set] + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back, write-allocate data cache with flush.
// Ports: clk, rst (async, high); CPU side addr, rd_req, wr_req, wr_data,
// wr_be, rd_data, miss, flush_req, flush_done; memory side mem_rd_req,
// mem_wr_req, mem_addr, mem_wr_line, mem_rd_line, mem_gnt.
// Define CACHE_PERF_CNT_EN to add hit_cnt, miss_cnt and wb_cnt outputs.
module cache_assoc_wb
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int TAG_ADDR_LEN  = 12,
    parameter int WAY_CNT       = 4,
    parameter int REPL_POLICY   = 1,
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN,
    localparam int LINE_W    = 32 * LINE_SIZE,
    localparam int MADDR_W   = TAG_ADDR_LEN + SET_ADDR_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic               rd_req,
    input  logic               wr_req,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_be,
    output logic [31:0]        rd_data,
    output logic               miss,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               mem_rd_req,
    output logic               mem_wr_req,
    output logic [MADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wr_line,
    input  logic [LINE_W-1:0]  mem_rd_line,
    input  logic               mem_gnt
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt,
    output logic [31:0]        wb_cnt
`endif
);

    localparam int SETS  = 1 << SET_ADDR_LEN;
    localparam int WAY_W = (WAY_CNT > 1) ? clog2(WAY_CNT) : 1;

    state_t state, next;

    logic [TAG_ADDR_LEN-1:0]  tag;
    logic [SET_ADDR_LEN-1:0]  set;
    logic [LINE_ADDR_LEN-1:0] word;

    logic [TAG_ADDR_LEN-1:0] tags  [SETS][WAY_CNT];
    logic [LINE_W-1:0]       lines [SETS][WAY_CNT];
    logic [WAY_CNT-1:0]      valid [SETS];
    logic [WAY_CNT-1:0]      dirty [SETS];

    logic                    access, hit, serve;
    logic [WAY_W-1:0]        hit_way, victim;
    logic [LINE_W-1:0]       cur_line, wr_line, fill_line;
    logic [31:0]             hit_word;
    logic                    victim_dirty;

    logic [SET_ADDR_LEN-1:0] req_set;
    logic [TAG_ADDR_LEN-1:0] req_tag;
    logic [WAY_W-1:0]        victim_r;
    logic [MADDR_W-1:0]      wb_addr;

    logic [SET_ADDR_LEN-1:0] scan_set;
    logic [WAY_W-1:0]        scan_way;
    logic                    scan_dirty, scan_last;

    assign tag  = TAG_ADDR_LEN'(addr_field(addr, SET_ADDR_LEN + LINE_ADDR_LEN + 2,
                                           TAG_ADDR_LEN));
    assign set  = SET_ADDR_LEN'(addr_field(addr, LINE_ADDR_LEN + 2, SET_ADDR_LEN));
    assign word = LINE_ADDR_LEN'(addr_field(addr, 2, LINE_ADDR_LEN));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (valid[set][w] && tags[set][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        cur_line = lines[set][hit_way];
        hit_word = cur_line[32 * int'(word) +: 32];
        wr_line  = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b])
                wr_line[32 * int'(word) + 8 * b +: 8] = wr_data[8 * b +: 8];
        end
    end

    assign access       = rd_req | wr_req;
    assign serve        = access & hit & (state == IDLE);
    assign miss         = access & ~serve;
    assign victim_dirty = valid[set][victim] & dirty[set][victim];
    assign scan_dirty   = valid[scan_set][scan_way] & dirty[scan_set][scan_way];
    assign scan_last    = (scan_set == SET_ADDR_LEN'(SETS - 1))
                        && (scan_way == WAY_W'(WAY_CNT - 1));

    // Requests are decoded from state so a reset drops them immediately.
    assign mem_rd_req = (state == SWAP_IN);
    assign mem_wr_req = (state == SWAP_OUT) || (state == FLUSH_OUT);
    assign mem_addr   = mem_wr_req ? wb_addr : {req_tag, req_set};

    cache_repl #(
        .SET_ADDR_LEN (SET_ADDR_LEN),
        .WAY_CNT      (WAY_CNT),
        .REPL_POLICY  (REPL_POLICY)
    ) u_repl (
        .clk     (clk),
        .rst     (rst),
        .set     (set),
        .valid   (valid[set]),
        .victim  (victim),
        .upd     (serve || state == SWAP_IN_OK),
        .fill    (state == SWAP_IN_OK),
        .upd_set ((state == SWAP_IN_OK) ? req_set : set),
        .upd_way ((state == SWAP_IN_OK) ? victim_r : hit_way)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (access && !hit)
                    next = victim_dirty ? SWAP_OUT : SWAP_IN;
                else if (!access && flush_req)
                    next = FLUSH_SCAN;
            end
            SWAP_OUT:   if (mem_gnt) next = SWAP_IN;
            SWAP_IN:    if (mem_gnt) next = SWAP_IN_OK;
            SWAP_IN_OK: next = IDLE;
            FLUSH_SCAN: begin
                if (scan_dirty)     next = FLUSH_OUT;
                else if (scan_last) next = IDLE;
            end
            FLUSH_OUT:  if (mem_gnt) next = scan_last ? IDLE : FLUSH_SCAN;
            default:    next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
            rd_data    <= '0;
            flush_done <= 1'b0;
            req_set    <= '0;
            req_tag    <= '0;
            victim_r   <= '0;
            scan_set   <= '0;
            scan_way   <= '0;
        end else begin
            flush_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (serve) begin
                        if (wr_req) dirty[set][hit_way] <= 1'b1;
                        else        rd_data <= hit_word;
                    end else if (access) begin
                        req_set  <= set;
                        req_tag  <= tag;
                        victim_r <= victim;
                    end else if (flush_req) begin
                        scan_set <= '0;
                        scan_way <= '0;
                    end
                end
                SWAP_IN_OK: begin
                    valid[req_set][victim_r] <= 1'b1;
                    dirty[req_set][victim_r] <= 1'b0;
                end
                FLUSH_SCAN: begin
                    if (!scan_dirty) begin
                        if (scan_last) begin
                            flush_done <= 1'b1;
                        end else if (scan_way == WAY_W'(WAY_CNT - 1)) begin
                            scan_way <= '0;
                            scan_set <= scan_set + SET_ADDR_LEN'(1);
                        end else begin
                            scan_way <= scan_way + WAY_W'(1);
                        end
                    end
                end
                FLUSH_OUT: begin
                    if (mem_gnt) begin
                        dirty[scan_set][scan_way] <= 1'b0;
                        if (scan_last) begin
                            flush_done <= 1'b1;
                        end else if (scan_way == WAY_W'(WAY_CNT - 1)) begin
                            scan_way <= '0;
                            scan_set <= scan_set + SET_ADDR_LEN'(1);
                        end else begin
                            scan_way <= scan_way + WAY_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage is not reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: begin
                if (serve && wr_req) begin
                    lines[set][hit_way] <= wr_line;
                end else if (access && !hit) begin
                    mem_wr_line <= lines[set][victim];
                    wb_addr     <= {tags[set][victim], set};
                end
            end
            SWAP_IN: if (mem_gnt) fill_line <= mem_rd_line;
            SWAP_IN_OK: begin
                lines[req_set][victim_r] <= fill_line;
                tags[req_set][victim_r]  <= req_tag;
            end
            FLUSH_SCAN: begin
                if (scan_dirty) begin
                    mem_wr_line <= lines[scan_set][scan_way];
                    wb_addr     <= {tags[scan_set][scan_way], scan_set};
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    // The hit right after a fill completes the access that missed; it is
    // not counted as a separate hit.
    logic post_fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_fill <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            wb_cnt    <= '0;
        end else begin
            if (state == SWAP_IN_OK) post_fill <= 1'b1;
            else if (state == IDLE)  post_fill <= 1'b0;
            if (serve && !post_fill && hit_cnt != '1)
                hit_cnt <= hit_cnt + 32'd1;
            if (state == IDLE && access && !hit && miss_cnt != '1)
                miss_cnt <= miss_cnt + 32'd1;
            if (mem_wr_req && mem_gnt && wb_cnt != '1)
                wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif

endmodule
